// File: rtl/fc_input_buffer_if.sv
// Stream interface of fc_input_buffer: upstream capture port, FC-side replay port and done pulse.
interface fc_input_buffer_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_W      = 9
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  out_ready;
  logic                  done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, done
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, done
  );
endinterface

// File: rtl/fc_input_buffer.sv
// Captures one flattened feature vector and replays it PASSES times to the FC stage in index order.
// Optional FC_INPUT_RELU_EN: negative words are stored as zero on capture.
module fc_input_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned INPUT_SIZE = 400,
  parameter int unsigned PASSES     = 120,
  parameter int unsigned IDX_W      = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  fc_input_buffer_if.slave   bus
);

  localparam int unsigned     PASS_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(INPUT_SIZE - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

  typedef enum logic [1:0] {FILL, PREFETCH, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [INPUT_SIZE];

  logic [IDX_W-1:0]      wr_cnt, wr_cnt_d;
  logic [IDX_W-1:0]      rd_cnt, rd_cnt_d;
  logic [IDX_W-1:0]      rd_addr, nxt_idx;
  logic [PASS_W-1:0]     pass_cnt, pass_cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, wr_data;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  wr_fire, rd_fire, rd_en, last_word, final_word;

  assign wr_fire    = (state == FILL) && in_ready_q && bus.in_valid;
  assign rd_fire    = (state == DRAIN) && out_valid_q && bus.out_ready;
  assign last_word  = (rd_cnt == LAST_IDX);
  assign final_word = last_word && (pass_cnt == LAST_PASS);
  assign nxt_idx    = last_word ? '0 : rd_cnt + IDX_W'(1);

`ifdef FC_INPUT_RELU_EN
  assign wr_data = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
`else
  assign wr_data = bus.in_data;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:     if (wr_fire && (wr_cnt == LAST_IDX)) state_nxt = PREFETCH;
      PREFETCH: state_nxt = DRAIN;
      DRAIN:    if (rd_fire && final_word) state_nxt = DONE;
      DONE:     state_nxt = FILL;
      default:  state_nxt = FILL;
    endcase
  end

  // Output / counter next values; the read port is enabled only when a new word is needed,
  // so the output word holds still while the FC stage stalls.
  always_comb begin
    in_ready_d  = (state_nxt == FILL);
    out_valid_d = (state_nxt == DRAIN);
    done_d      = (state_nxt == DONE);
    out_last_d  = out_last_q;
    wr_cnt_d    = wr_cnt;
    rd_cnt_d    = rd_cnt;
    pass_cnt_d  = pass_cnt;
    rd_en       = 1'b0;
    rd_addr     = rd_cnt;
    case (state)
      FILL: begin
        if (wr_fire) wr_cnt_d = (wr_cnt == LAST_IDX) ? '0 : wr_cnt + IDX_W'(1);
      end
      PREFETCH: begin
        rd_en      = 1'b1;
        rd_addr    = '0;
        rd_cnt_d   = '0;
        out_last_d = (LAST_IDX == '0);
      end
      DRAIN: begin
        if (rd_fire) begin
          if (final_word) begin
            rd_cnt_d   = '0;
            pass_cnt_d = '0;
            out_last_d = 1'b0;
          end else begin
            rd_en      = 1'b1;
            rd_addr    = nxt_idx;
            rd_cnt_d   = nxt_idx;
            out_last_d = (nxt_idx == LAST_IDX);
            if (last_word) pass_cnt_d = pass_cnt + PASS_W'(1);
          end
        end
      end
      DONE: begin
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        pass_cnt_d = '0;
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      pass_cnt    <= '0;
      out_data_q  <= '0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      wr_cnt      <= wr_cnt_d;
      rd_cnt      <= rd_cnt_d;
      pass_cnt    <= pass_cnt_d;
      if (rd_en) out_data_q <= mem[rd_addr];
    end
  end

  // Vector storage write port
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_cnt] <= wr_data;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = rd_cnt;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fc_input_buffer.sv
// Bench for fc_input_buffer: cycle table on a 1-word/1-pass instance, model-checked random runs on 400x4.
`timescale 1ns/1ps
module tb_fc_input_buffer;

  localparam int unsigned DW  = 16;
  localparam int unsigned NA  = 400;
  localparam int unsigned PA  = 4;
  localparam int unsigned IWA = 9;
  localparam int PH_FILL = 0, PH_WAIT = 1, PH_DRAIN = 2, PH_DONE = 3;
  localparam int MAX_CYC = 20000;

  logic clk = 1'b0;
  logic rst_a, rst_c;
  always #5 clk = ~clk;

  fc_input_buffer_if #(.DATA_WIDTH(DW), .IDX_W(IWA)) bus_a ();
  fc_input_buffer_if #(.DATA_WIDTH(DW), .IDX_W(1))   bus_c ();

  fc_input_buffer #(.DATA_WIDTH(DW), .INPUT_SIZE(NA), .PASSES(PA), .IDX_W(IWA)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a)
  );
  fc_input_buffer #(.DATA_WIDTH(DW), .INPUT_SIZE(1), .PASSES(1), .IDX_W(1)) dut_c (
    .clk(clk), .rst(rst_c), .bus(bus_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] w);
`ifdef FC_INPUT_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // ---------------- cycle table for the INPUT_SIZE=1, PASSES=1 instance ----------------
  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ir;
    logic          e_ov;
    logic          e_done;
    logic          e_last;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ordy,
                              input logic ir, input logic ov, input logic dn,
                              input logic last, input logic [DW-1:0] ed);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = ir; v.e_ov = ov; v.e_done = dn; v.e_last = last; v.e_data = ed;
    return v;
  endfunction

  // ---------------- reference model for the 400x4 instance ----------------
  logic [DW-1:0] vec_q[$];
  int phase;
  int k;

  function automatic logic [DW-1:0] gen_word(input int mode, input int i);
    case (mode)
      0:       return DW'(i);
      1:       return (i % 2 == 0) ? 16'h8001 : 16'h0005;
      default: return DW'($urandom);
    endcase
  endfunction

  // One complete vector: fill, PA passes of drain, done. Returns early at drain word abort_k.
  task automatic run_vector(input int mode, input int gap_pct, input int stall_pct,
                            input int drain_iv_pct, input int abort_k, output bit aborted);
    int src;
    int cyc;
    vec_q.delete();
    phase   = PH_FILL;
    k       = 0;
    src     = 0;
    cyc     = 0;
    aborted = 1'b0;
    while (1) begin
      @(negedge clk);
      if (phase == PH_DRAIN && k == abort_k) begin
        aborted = 1'b1;
        break;
      end
      if (cyc++ > MAX_CYC) begin
        check("vector_timeout", 64'(phase), 64'(PH_FILL + 100));
        break;
      end
      if (phase == PH_FILL) begin
        bus_a.in_valid = ($urandom_range(99) >= 32'(gap_pct));
        bus_a.in_data  = gen_word(mode, src);
      end else begin
        bus_a.in_valid = ($urandom_range(99) < 32'(drain_iv_pct));
        bus_a.in_data  = DW'($urandom);
      end
      bus_a.out_ready = ($urandom_range(99) >= 32'(stall_pct));

      case (phase)
        PH_FILL: begin
          check("fill_in_ready", 64'(bus_a.in_ready), 64'(1));
          check("fill_out_valid", 64'(bus_a.out_valid), 64'(0));
          check("fill_done", 64'(bus_a.done), 64'(0));
          if (bus_a.in_valid && bus_a.in_ready) begin
            vec_q.push_back(relu(bus_a.in_data));
            src++;
            if (vec_q.size() == NA) phase = PH_WAIT;
          end
        end
        PH_WAIT: begin
          check("latency_in_ready", 64'(bus_a.in_ready), 64'(0));
          check("latency_out_valid", 64'(bus_a.out_valid), 64'(0));
          phase = PH_DRAIN;
        end
        PH_DRAIN: begin
          check("drain_in_ready", 64'(bus_a.in_ready), 64'(0));
          check("drain_out_valid", 64'(bus_a.out_valid), 64'(1));
          check("drain_done", 64'(bus_a.done), 64'(0));
          if (bus_a.out_valid) begin
            check("drain_data", 64'(bus_a.out_data), 64'(vec_q[k % NA]));
            check("drain_index", 64'(bus_a.out_index), 64'(k % NA));
            check("drain_last", 64'(bus_a.out_last), 64'((k % NA) == NA - 1));
            if (bus_a.out_ready) begin
              k++;
              if (k == NA * PA) phase = PH_DONE;
            end
          end
        end
        default: begin
          check("done_pulse", 64'(bus_a.done), 64'(1));
          check("done_out_valid", 64'(bus_a.out_valid), 64'(0));
          check("done_in_ready", 64'(bus_a.in_ready), 64'(0));
          break;
        end
      endcase
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_in_ready"}, 64'(bus_a.in_ready), 64'(0));
    check({tag, "_out_valid"}, 64'(bus_a.out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(bus_a.out_data), 64'(0));
    check({tag, "_out_index"}, 64'(bus_a.out_index), 64'(0));
    check({tag, "_out_last"}, 64'(bus_a.out_last), 64'(0));
    check({tag, "_done"}, 64'(bus_a.done), 64'(0));
  endtask

  initial begin
    bit ab;
    logic [63:0] act, exp;

    rst_a = 1'b1; rst_c = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_c.in_valid = 1'b0; bus_c.in_data = '0; bus_c.out_ready = 1'b0;

    tbl[0]  = mk(1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    tbl[3]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    tbl[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    tbl[5]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[6]  = mk(1'b1, 16'hFFFB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, relu(16'hFFFB));
    tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    tbl[9]  = mk(1'b1, 16'h0042, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[10] = mk(1'b1, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0042);
    tbl[12] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    tbl[13] = mk(1'b1, 16'h0099, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[14] = mk(1'b1, 16'h0099, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tbl[15] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0099);
    tbl[16] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);

    repeat (3) @(negedge clk);
    check("c_reset_in_ready", 64'(bus_c.in_ready), 64'(0));
    check("c_reset_out_valid", 64'(bus_c.out_valid), 64'(0));
    check("c_reset_done", 64'(bus_c.done), 64'(0));
    check("c_reset_out_data", 64'(bus_c.out_data), 64'(0));
    check_reset_a("a_reset");

    // Single-word, single-pass corner: table of per-cycle inputs and post-edge outputs
    rst_c = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus_c.in_valid  = tbl[i].iv;
      bus_c.in_data   = tbl[i].d;
      bus_c.out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      act = {39'd0, bus_c.in_ready, bus_c.out_valid, bus_c.done,
             bus_c.out_valid ? bus_c.out_last : 1'b0,
             bus_c.out_valid ? bus_c.out_index : 1'b0,
             bus_c.out_valid ? bus_c.out_data : 16'h0000};
      exp = {39'd0, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_done, tbl[i].e_last, 1'b0, tbl[i].e_data};
      if (act !== exp) $display("FAIL tbl_row_%0d: got %0h, expected %0h", i, act, exp);
      checks++;
      if (act !== exp) errors++;
      @(negedge clk);
    end

    // 400-word, 4-pass instance
    rst_a = 1'b0;
    @(posedge clk);
    run_vector(0, 0, 0, 0, -1, ab);      // in_data = index, no gaps, no backpressure
    run_vector(2, 30, 50, 50, -1, ab);   // random data, upstream gaps, 50% backpressure
    run_vector(1, 0, 0, 100, -1, ab);    // alternating negative/positive, in_valid held in drain

    // Reset in the middle of pass 3, index 57
    run_vector(2, 10, 30, 50, 3 * NA + 57, ab);
    check("abort_reached", 64'(ab), 64'(1));
    check("abort_index", 64'(bus_a.out_index), 64'(57));
    rst_a = 1'b1;
    #1;
    check_reset_a("mid_drain_reset");
    @(negedge clk);
    rst_a = 1'b0;
    @(posedge clk);
    run_vector(0, 0, 20, 100, -1, ab);   // fresh fill streams from index 0

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
